segmem_ctrl: RTL and testbench

SEGMEM_CTRL -- requirements
Module: segmem_ctrl

---
 rtl/segmem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_segmem_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/segmem_ctrl.sv
// Segmented data memory controller with instruction ROM port and memory-mapped IO status word.
// Optional sticky unmapped-access fault capture is built when SEGMEM_FAULT_EN is defined.
module segmem_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned IWIDTH     = 24,
    parameter int unsigned SEG0_WORDS = 32,
    parameter int unsigned SEG1_WORDS = 1024,
    parameter int unsigned SEG2_WORDS = 512,
    parameter int unsigned IMEM_WORDS = 1024,
    parameter int unsigned IO_ADDR    = 1568
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  iaddr,
    output logic [IWIDTH-1:0] irdata,
    output logic              ivalid,
    input  logic              dreq,
    input  logic              dwe,
    input  logic [WIDTH-1:0]  daddr,
    input  logic [WIDTH-1:0]  dwdata,
    output logic              dready,
    output logic              drvalid,
    output logic [WIDTH-1:0]  drdata,
    input  logic              start_io,
    output logic              io_done,
    output logic              fault,
    output logic [WIDTH-1:0]  fault_addr
);

    localparam int unsigned S0A = $clog2(SEG0_WORDS);
    localparam int unsigned S1A = $clog2(SEG1_WORDS);
    localparam int unsigned S2A = $clog2(SEG2_WORDS);
    localparam int unsigned IA  = $clog2(IMEM_WORDS);

    localparam logic [WIDTH-1:0] Seg1Base = WIDTH'(SEG0_WORDS);
    localparam logic [WIDTH-1:0] Seg2Base = WIDTH'(SEG0_WORDS + SEG1_WORDS);
    localparam logic [WIDTH-1:0] SegEnd   = WIDTH'(SEG0_WORDS + SEG1_WORDS + SEG2_WORDS);
    localparam logic [WIDTH-1:0] IoAddr   = WIDTH'(IO_ADDR);

    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

    state_e             state_q, state_d;
    logic               we_q;
    logic [WIDTH-1:0]   addr_q, wdata_q, drdata_q, rd_word;
    logic               io_done_q, ivalid_q;
    logic [1:0]         sync_q;
    logic [IWIDTH-1:0]  irdata_q;
    logic [IA-1:0]      imem_idx;
    logic               is_io, in_seg0, in_seg1, in_seg2, access_we;
    logic [S0A-1:0]     off0;
    logic [S1A-1:0]     off1;
    logic [S2A-1:0]     off2;

    logic [WIDTH-1:0] seg0_mem [SEG0_WORDS];
    logic [WIDTH-1:0] seg1_mem [SEG1_WORDS];
    logic [WIDTH-1:0] seg2_mem [SEG2_WORDS];

    // Instruction ROM image: word i holds i until a program image is substituted here.
    function automatic logic [IWIDTH-1:0] rom_word(logic [IA-1:0] idx);
        return IWIDTH'(idx);
    endfunction

    assign imem_idx = IA'(iaddr % WIDTH'(IMEM_WORDS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ivalid_q <= 1'b0;
            irdata_q <= '0;
        end else begin
            ivalid_q <= 1'b1;
            irdata_q <= rom_word(imem_idx);
        end
    end

    assign ivalid = ivalid_q;
    assign irdata = irdata_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        dready  = 1'b0;
        drvalid = 1'b0;
        unique case (state_q)
            StIdle: begin
                dready = 1'b1;
                if (dreq) state_d = StAccess;
            end
            StAccess: state_d = we_q ? StIdle : StResp;
            StResp: begin
                drvalid = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state_q == StIdle && dreq) begin
            we_q    <= dwe;
            addr_q  <= daddr;
            wdata_q <= dwdata;
        end
    end

    assign is_io   = (addr_q == IoAddr);
    assign in_seg0 = !is_io && (addr_q < Seg1Base);
    assign in_seg1 = !is_io && (addr_q >= Seg1Base) && (addr_q < Seg2Base);
    assign in_seg2 = !is_io && (addr_q >= Seg2Base) && (addr_q < SegEnd);
    assign off0    = S0A'(addr_q);
    assign off1    = S1A'(addr_q - Seg1Base);
    assign off2    = S2A'(addr_q - Seg2Base);

    // Gate with reset so an access interrupted by reset never lands in the arrays.
    assign access_we = (state_q == StAccess) && we_q && !reset;

    always_ff @(posedge clk) begin
        if (access_we && in_seg0) seg0_mem[off0] <= wdata_q;
        if (access_we && in_seg1) seg1_mem[off1] <= wdata_q;
        if (access_we && in_seg2) seg2_mem[off2] <= wdata_q;
    end

    always_comb begin
        rd_word = '0;
        if (is_io)        rd_word[1:0] = {io_done_q, sync_q[1]};
        else if (in_seg0) rd_word = seg0_mem[off0];
        else if (in_seg1) rd_word = seg1_mem[off1];
        else if (in_seg2) rd_word = seg2_mem[off2];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drdata_q  <= '0;
            io_done_q <= 1'b0;
            sync_q    <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], start_io};
            if (state_q == StAccess) begin
                if (!we_q)      drdata_q  <= rd_word;
                else if (is_io) io_done_q <= wdata_q[0];
            end
        end
    end

    assign drdata  = drdata_q;
    assign io_done = io_done_q;

`ifdef SEGMEM_FAULT_EN
    logic             unmapped;
    logic             fault_q;
    logic [WIDTH-1:0] fault_addr_q;

    assign unmapped = !(is_io || in_seg0 || in_seg1 || in_seg2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else if (state_q == StAccess && unmapped && !fault_q) begin
            fault_q      <= 1'b1;
            fault_addr_q <= addr_q;
        end
    end

    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
`else
    assign fault      = 1'b0;
    assign fault_addr = '0;
`endif

endmodule

// File: tb/tb_segmem_ctrl.sv
// Directed plus randomized bench for segmem_ctrl against an address-level memory/IO model.
module tb_segmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] iaddr;
    logic [23:0] irdata;
    logic        ivalid;
    logic        dreq, dwe;
    logic [31:0] daddr, dwdata;
    logic        dready, drvalid;
    logic [31:0] drdata;
    logic        start_io;
    logic        io_done;
    logic        fault;
    logic [31:0] fault_addr;

    int checks   = 0;
    int failures = 0;

    // Address-level model: words known by address, IO bits, first-fault capture.
    logic [31:0] mem_m [int];
    logic        io_done_m = 1'b0;
    logic        start_m   = 1'b0;
    logic        fault_m   = 1'b0;
    logic [31:0] faddr_m   = 32'd0;

    segmem_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .iaddr      (iaddr),
        .irdata     (irdata),
        .ivalid     (ivalid),
        .dreq       (dreq),
        .dwe        (dwe),
        .daddr      (daddr),
        .dwdata     (dwdata),
        .dready     (dready),
        .drvalid    (drvalid),
        .drdata     (drdata),
        .start_io   (start_io),
        .io_done    (io_done),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        if (a == 32'd1568) return {30'd0, io_done_m, start_m};
        if (a < 32'd1568)  return mem_m[int'(a)];
        return 32'd0;
    endfunction

    function automatic bit model_known(input logic [31:0] a);
        return (a >= 32'd1568) || mem_m.exists(int'(a));
    endfunction

    task automatic model_access(input logic [31:0] a, input logic we, input logic [31:0] d);
        if (a > 32'd1568 && !fault_m) begin
            fault_m = 1'b1;
            faddr_m = a;
        end
        if (we) begin
            if (a == 32'd1568)     io_done_m = d[0];
            else if (a < 32'd1568) mem_m[int'(a)] = d;
        end
    endtask

    task automatic chk_fault();
`ifdef SEGMEM_FAULT_EN
        chk("fault", {31'd0, fault}, {31'd0, fault_m});
        chk("fault_addr", fault_addr, faddr_m);
`else
        chk("fault_off", {31'd0, fault}, 32'd0);
        chk("fault_addr_off", fault_addr, 32'd0);
`endif
    endtask

    // All transaction tasks start and end on a falling edge with the FSM idle.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        chk("wr_dready_idle", {31'd0, dready}, 32'd1);
        dreq = 1'b1; dwe = 1'b1; daddr = a; dwdata = d;
        @(negedge clk);
        dreq = 1'b0; dwe = 1'b0;
        chk("wr_dready_access", {31'd0, dready}, 32'd0);
        model_access(a, 1'b1, d);
        @(negedge clk);
        chk("wr_no_drvalid", {31'd0, drvalid}, 32'd0);
        chk("io_done", {31'd0, io_done}, {31'd0, io_done_m});
        chk_fault();
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0] exp;
        chk("rd_dready_idle", {31'd0, dready}, 32'd1);
        dreq = 1'b1; dwe = 1'b0; daddr = a;
        @(negedge clk);
        dreq = 1'b0;
        chk("rd_drvalid_access", {31'd0, drvalid}, 32'd0);
        model_access(a, 1'b0, 32'd0);
        exp = model_rd(a);
        @(negedge clk);
        chk("rd_drvalid_resp", {31'd0, drvalid}, 32'd1);
        chk("rd_drdata", drdata, exp);
        @(negedge clk);
        chk("rd_drvalid_after", {31'd0, drvalid}, 32'd0);
        chk("rd_drdata_hold", drdata, exp);
        chk_fault();
    endtask

    initial begin
        logic [31:0] pool [14];
        logic [31:0] a;
        pool = '{32'd0, 32'd5, 32'd31, 32'd32, 32'd33, 32'd100, 32'd1055,
                 32'd1056, 32'd1057, 32'd1567, 32'd1568, 32'd1569, 32'd2000, 32'd40};

        reset = 1'b1; iaddr = 32'd0; dreq = 1'b0; dwe = 1'b0;
        daddr = 32'd0; dwdata = 32'd0; start_io = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dready", {31'd0, dready}, 32'd1);
        chk("rst_drvalid", {31'd0, drvalid}, 32'd0);
        chk("rst_drdata", drdata, 32'd0);
        chk("rst_ivalid", {31'd0, ivalid}, 32'd0);
        chk("rst_irdata", {8'd0, irdata}, 32'd0);
        chk("rst_io_done", {31'd0, io_done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_fault_addr", fault_addr, 32'd0);
        reset = 1'b0;

        // Instruction port: one registered fetch per cycle, address wraps modulo depth.
        for (int i = 0; i < 8; i++) begin
            a = (i == 0) ? 32'd1023 : (i == 1) ? 32'd1024 : $urandom;
            iaddr = a;
            @(negedge clk);
            chk("ivalid", {31'd0, ivalid}, 32'd1);
            chk("irdata", {8'd0, irdata}, a % 32'd1024);
        end

        // Basic write/read with other segments untouched.
        do_write(32'd100, 32'h1234_5678);
        do_write(32'd1100, 32'h0BAD_F00D);
        do_write(32'd40, 32'hAAAA_0040);
        do_write(32'd5, 32'hDEAD_BEEF);
        do_read(32'd5);
        do_read(32'd100);
        do_read(32'd1100);

        // Segment boundary seg0/seg1 and seg2 last word.
        do_write(32'd31, 32'h0000_0011);
        do_write(32'd32, 32'h0000_0022);
        do_write(32'd1567, 32'h7777_1567);
        do_read(32'd31);
        do_read(32'd32);
        do_read(32'd1567);

        // IO status word through the start_io synchroniser.
        start_io = 1'b1;
        repeat (3) @(negedge clk);
        start_m = 1'b1;
        do_read(32'd1568);
        do_write(32'd1568, 32'h0000_0001);
        do_read(32'd1568);

        // Unmapped accesses: zero data, first address latched when the fault feature is built.
        do_read(32'd2000);
        do_read(32'd3000);
        do_write(32'd4000, 32'hFFFF_FFFF);

        // Continuous requests: one accept per three cycles, one response each.
        dreq = 1'b1; dwe = 1'b0; daddr = 32'd5;
        for (int i = 0; i < 9; i++) begin
            chk("stream_dready", {31'd0, dready}, (i % 3 == 0) ? 32'd1 : 32'd0);
            chk("stream_drvalid", {31'd0, drvalid}, (i % 3 == 2) ? 32'd1 : 32'd0);
            if (i % 3 == 2) chk("stream_drdata", drdata, model_rd(32'd5));
            if (i == 8) dreq = 1'b0;
            @(negedge clk);
        end

        // Randomized mix over boundary-heavy addresses.
        for (int n = 0; n < 80; n++) begin
            int unsigned k;
            k = $urandom_range(0, 14);
            a = (k == 14) ? 32'($urandom_range(0, 2100)) : pool[k];
            if ($urandom_range(0, 1) == 1 && model_known(a)) do_read(a);
            else do_write(a, $urandom);
        end

        // Reset during a write access aborts it.
        do_read(32'd40);
        dreq = 1'b1; dwe = 1'b1; daddr = 32'd40; dwdata = 32'h5555_5555;
        @(posedge clk);
        #2;
        reset = 1'b1;
        dreq = 1'b0; dwe = 1'b0;
        @(negedge clk);
        chk("abort_dready_in_rst", {31'd0, dready}, 32'd1);
        chk("abort_ivalid_in_rst", {31'd0, ivalid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        io_done_m = 1'b0; fault_m = 1'b0; faddr_m = 32'd0;
        @(negedge clk);
        chk("abort_dready", {31'd0, dready}, 32'd1);
        chk("abort_drvalid", {31'd0, drvalid}, 32'd0);
        chk("abort_drdata", drdata, 32'd0);
        chk("abort_io_done", {31'd0, io_done}, 32'd0);
        chk_fault();
        repeat (2) @(negedge clk);
        do_read(32'd40);
        do_read(32'd1568);
        do_read(32'd2500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
